// File: rtl/pci_bus_arbiter.sv
// pci_bus_arbiter
//   Central round-robin arbiter for a shared PCI bus. It samples the active-low
//   requests, drives at most one active-low grant, detects bus idle from
//   FRAME/IRDY, keeps at least one all-high grant cycle between owners, and
//   revokes a grant that the master does not use within GNT_TIMEOUT cycles.
//
// Ports
//   i_clk          bus clock, all state changes on the rising edge
//   i_rst          asynchronous active-high reset
//   i_req          active-low requests, bit i = master i
//   i_frame        active-low FRAME (sampled)
//   i_irdy         active-low IRDY (sampled)
//   o_gnt          active-low grants, at most one bit low
//   o_owner        index of the current or most recently granted master
//   o_owner_valid  high while a grant bit is low
//   o_timeout_evt  one-cycle pulse when an unused grant is revoked
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no grant; grant the round-robin pick on the next edge
// ST_GRANTED | o_owner holds the grant; watch timeout, release, preempt
// ST_TURN    | turnaround: all grants high until the bus is sampled idle

module pci_bus_arbiter #(
  parameter int N_MASTERS   = 4,
  parameter int GNT_TIMEOUT = 16,
  parameter int OW          = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N_MASTERS-1:0] i_req,
  input  logic                 i_frame,
  input  logic                 i_irdy,
  output logic [N_MASTERS-1:0] o_gnt,
  output logic [OW-1:0]        o_owner,
  output logic                 o_owner_valid,
  output logic                 o_timeout_evt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANTED = 2'd1,
    ST_TURN    = 2'd2
  } state_t;

  localparam int            CW       = $clog2(GNT_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(GNT_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  state_t                 r_state;
  logic [OW-1:0]          r_last;
  logic [CW-1:0]          r_cnt;
  logic                   r_started;

  logic [N_MASTERS-1:0]   w_req_act;
  logic [N_MASTERS-1:0]   w_own_oh;
  logic [N_MASTERS-1:0]   w_pick_oh;
  logic [OW-1:0]          w_pick;
  logic                   w_any;
  logic                   w_bus_idle;
  logic                   w_owner_req;
  logic                   w_others_req;
  logic                   w_exit_to;
  logic                   w_exit_done;
  logic                   w_exit_pre;

  // Request decode and round-robin pick. Only an explicit 0 counts as a
  // request, so X/Z bits never win. The search starts one past r_last; the
  // loop runs from the farthest candidate down so the nearest requester is
  // the last assignment and wins. Wrap is modulo N_MASTERS, so codes above
  // N_MASTERS-1 are never produced.
  always_comb begin
    w_req_act = '0;
    w_own_oh  = '0;
    w_pick_oh = '0;
    w_pick    = '0;
    w_any     = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      w_req_act[i] = (i_req[i] == 1'b0);
      w_own_oh[i]  = (o_owner == OW'(i));
    end
    for (int l = 0; l < N_MASTERS; l++) begin
      if (r_last == OW'(l)) begin
        for (int k = N_MASTERS; k >= 1; k--) begin
          if (w_req_act[(l + k) % N_MASTERS]) begin
            w_pick = OW'((l + k) % N_MASTERS);
            w_any  = 1'b1;
          end
        end
      end
    end
    for (int i = 0; i < N_MASTERS; i++) begin
      w_pick_oh[i] = w_any && (w_pick == OW'(i));
    end
  end

  assign w_bus_idle   = (i_frame == 1'b1) && (i_irdy == 1'b1);
  assign w_owner_req  = |(w_req_act & w_own_oh);
  assign w_others_req = |(w_req_act & ~w_own_oh);

  // GRANTED exits, evaluated on registered cnt/started. The priority chain
  // in the FSM below takes timeout first, then owner release, then preempt.
  assign w_exit_to   = !r_started && (r_cnt == CNT_LAST);
  assign w_exit_done = !w_owner_req && w_bus_idle;
  assign w_exit_pre  = r_started && w_others_req;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_last        <= OW'(N_MASTERS - 1);
      r_cnt         <= '0;
      r_started     <= 1'b0;
      o_gnt         <= '1;
      o_owner       <= '0;
      o_owner_valid <= 1'b0;
      o_timeout_evt <= 1'b0;
    end else begin
      o_timeout_evt <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          o_gnt         <= '1;
          o_owner_valid <= 1'b0;
          if (w_any) begin
            o_gnt         <= ~w_pick_oh;
            o_owner       <= w_pick;
            o_owner_valid <= 1'b1;
            r_last        <= w_pick;
            r_cnt         <= '0;
            r_started     <= 1'b0;
            r_state       <= ST_GRANTED;
          end
        end

        ST_GRANTED: begin
          if (!r_started && (i_frame == 1'b0)) begin
            r_started <= 1'b1;
          end
          if (!r_started && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CW'(1);
          end
          if (w_exit_to) begin
            o_gnt         <= '1;
            o_owner_valid <= 1'b0;
            o_timeout_evt <= 1'b1;
            r_state       <= ST_TURN;
          end else if (w_exit_done || w_exit_pre) begin
            // On preempt the owner finishes its transaction under its own
            // latency timer; the turnaround state waits for the bus to idle.
            o_gnt         <= '1;
            o_owner_valid <= 1'b0;
            r_state       <= ST_TURN;
          end
        end

        ST_TURN: begin
          o_gnt         <= '1;
          o_owner_valid <= 1'b0;
          if (w_bus_idle) begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          o_gnt         <= '1;
          o_owner_valid <= 1'b0;
          r_state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pci_bus_arbiter.sv
module tb_pci_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       frame;
  logic       irdy;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       valid;
  logic       tmo;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pci_bus_arbiter #(
    .N_MASTERS  (4),
    .GNT_TIMEOUT(16),
    .OW         (2)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req        (req),
    .i_frame      (frame),
    .i_irdy       (irdy),
    .o_gnt        (gnt),
    .o_owner      (owner),
    .o_owner_valid(valid),
    .o_timeout_evt(tmo)
  );

  typedef struct {
    logic [3:0] req;
    logic       frame;
    logic       irdy;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       valid;
    logic       tmo;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req   = 4'hF;
    frame = 1'b1;
    irdy  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_g;
    int         gap;
    int         low;
    int         pulses;
    int         seen;

    // req, frame, irdy -> gnt, owner, valid, tmo (after the edge)
    tbl[0]  = '{4'b1111, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{4'b1110, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b1, 1'b0};
    tbl[2]  = '{4'b1110, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b1, 1'b0};
    tbl[3]  = '{4'b1110, 1'b0, 1'b1, 4'b1110, 2'd0, 1'b1, 1'b0};
    tbl[4]  = '{4'b1110, 1'b0, 1'b0, 4'b1110, 2'd0, 1'b1, 1'b0};
    tbl[5]  = '{4'b1111, 1'b1, 1'b0, 4'b1110, 2'd0, 1'b1, 1'b0};
    tbl[6]  = '{4'b1111, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0};
    tbl[7]  = '{4'b1111, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0};
    tbl[8]  = '{4'b1011, 1'b1, 1'b1, 4'b1011, 2'd2, 1'b1, 1'b0};
    tbl[9]  = '{4'b1001, 1'b0, 1'b0, 4'b1011, 2'd2, 1'b1, 1'b0};
    tbl[10] = '{4'b1001, 1'b0, 1'b0, 4'b1111, 2'd2, 1'b0, 1'b0};
    tbl[11] = '{4'b1001, 1'b0, 1'b0, 4'b1111, 2'd2, 1'b0, 1'b0};
    tbl[12] = '{4'b1001, 1'b1, 1'b1, 4'b1111, 2'd2, 1'b0, 1'b0};
    tbl[13] = '{4'b1001, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b1, 1'b0};
    tbl[14] = '{4'b1011, 1'b1, 1'b1, 4'b1111, 2'd1, 1'b0, 1'b0};
    tbl[15] = '{4'b1111, 1'b1, 1'b1, 4'b1111, 2'd1, 1'b0, 1'b0};
    tbl[16] = '{4'b0111, 1'b1, 1'b1, 4'b0111, 2'd3, 1'b1, 1'b0};

    // Reset with no requests: grants stay high for 10 cycles
    do_reset();
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_tmo", 32'(tmo), 32'd0);
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("idle%0d_gnt", c), 32'(gnt), 32'hF);
      chk($sformatf("idle%0d_valid", c), 32'(valid), 32'd0);
    end

    // Directed per-cycle vectors
    do_reset();
    for (int i = 0; i < 17; i++) begin
      req   = tbl[i].req;
      frame = tbl[i].frame;
      irdy  = tbl[i].irdy;
      step();
      chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("vec%0d_owner", i), 32'(owner), 32'(tbl[i].owner));
      chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(tbl[i].valid));
      chk($sformatf("vec%0d_tmo", i), 32'(tmo), 32'(tbl[i].tmo));
    end

    // All masters requesting, one transaction per grant: 0,1,2,3,0
    do_reset();
    req = 4'b0000;
    gap = 0;
    for (int g = 0; g < 5; g++) begin
      for (int b = 0; b < 10 && !valid; b++) begin
        step();
        if (gnt == 4'hF) gap++;
      end
      exp_g = 4'hF;
      exp_g[g % 4] = 1'b0;
      chk($sformatf("rr%0d_valid", g), 32'(valid), 32'd1);
      chk($sformatf("rr%0d_owner", g), 32'(owner), 32'(g % 4));
      chk($sformatf("rr%0d_gnt", g), 32'(gnt), 32'(exp_g));
      if (g > 0) chk($sformatf("rr%0d_gap", g), 32'(gap >= 1), 32'd1);
      frame = 1'b0;
      irdy  = 1'b0;
      step();
      frame = 1'b1;
      irdy  = 1'b1;
      step();
      chk($sformatf("rr%0d_release", g), 32'(gnt), 32'hF);
      gap = (gnt == 4'hF) ? 1 : 0;
    end
    req = 4'hF;

    // Unused grant to master 1 is revoked after exactly 16 cycles
    do_reset();
    req    = 4'b1101;
    low    = 0;
    pulses = 0;
    seen   = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (tmo) pulses++;
      if (!gnt[1]) begin
        low++;
        seen = 1;
      end else if (seen != 0) begin
        break;
      end
    end
    chk("tmo_gnt_low_cycles", 32'(low), 32'd16);
    chk("tmo_pulses", 32'(pulses), 32'd1);
    chk("tmo_gnt_after", 32'(gnt), 32'hF);
    step();
    chk("tmo_pulse_width", 32'(tmo), 32'd0);
    req = 4'hF;

    // Preempt: master 0 mid-transaction, master 2 requests
    do_reset();
    req = 4'b1110;
    step();
    chk("pre_gnt0", 32'(gnt), 32'hE);
    frame = 1'b0;
    irdy  = 1'b0;
    step();
    chk("pre_started", 32'(gnt), 32'hE);
    req = 4'b1010;
    step();
    chk("pre_gnt0_high", 32'(gnt), 32'hF);
    step();
    chk("pre_turn1", 32'(gnt), 32'hF);
    step();
    chk("pre_turn2", 32'(gnt), 32'hF);
    frame = 1'b1;
    irdy  = 1'b1;
    step();
    chk("pre_idle_seen", 32'(gnt), 32'hF);
    step();
    chk("pre_gnt2", 32'(gnt), 32'hB);
    chk("pre_owner2", 32'(owner), 32'd2);

    // Asynchronous reset mid-grant, then master 0 wins first
    do_reset();
    req = 4'b1011;
    step();
    chk("arst_pre_gnt", 32'(gnt), 32'hB);
    #3 rst = 1'b1;
    #1;
    chk("arst_gnt", 32'(gnt), 32'hF);
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_owner", 32'(owner), 32'd0);
    #2 rst = 1'b0;
    req = 4'b1010;
    step();
    chk("arst_first_gnt", 32'(gnt), 32'hE);
    chk("arst_first_owner", 32'(owner), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
